bg_pe_stream: RTL and testbench
===============================

# bg_pe_stream

Parametrised streaming successor of the background-removal processing element. It accepts a frame tile of `NUM_PIXELS` RGB pixels over a valid/ready stream and buffers the tile internally. It computes the per-channel mean itself, then streams the tile back out, replacing every pixel within `Threshold` of the mean by the desired background colour. The block adds a selectable distance mode and a replaced-pixel count. It sits between the pixel loader and the frame writer; several instances run in parallel, one per tile.

## Interface
Parameters:
- `PIX_W`, 8: bits per colour channel.
- `NUM_PIXELS`, 16: pixels per tile. Must be a power of two, ≥2. `LOG2_N = $clog2(NUM_PIXELS)`.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `Start` in 1: begin a tile; sampled only in IDLE.
- `Ack` in 1: release from DONE.
- `Mode` in 1: distance metric. 0 = L-inf (max channel difference), 1 = L1 (sum of channel differences). Latched at Start.
- `Threshold` in `PIX_W+2`: replace when distance ≤ Threshold. Latched at Start.
- `Bg_R`, `Bg_G`, `Bg_B` in `PIX_W` each: replacement colour. Latched at Start.
- `In_Valid` in 1, `In_Ready` out 1: input pixel handshake.
- `In_R`, `In_G`, `In_B` in `PIX_W` each: input pixel.
- `Out_Valid` out 1, `Out_Ready` in 1: output pixel handshake.
- `Out_R`, `Out_G`, `Out_B` out `PIX_W` each: output pixel.
- `Out_Replaced` out 1: current output pixel was replaced.
- `Mean_R`, `Mean_G`, `Mean_B` out `PIX_W` each: tile mean, valid from EMIT onward.
- `Replace_Count` out `LOG2_N+1`: replaced pixels in the current/last tile.
- `Qi`, `Ql`, `Qm`, `Qe`, `Qd` out 1 each: one-hot state flags.

## Operation
States and transitions:
- IDLE → LOAD on `Start`.
- LOAD → MEAN after the `NUM_PIXELS`-th input transfer.
- MEAN → EMIT, unconditionally (one cycle).
- EMIT → DONE after the `NUM_PIXELS`-th output transfer.
- DONE → IDLE on `Ack`.

Behaviour by state:
- LOAD: `In_Ready`=1. Each `In_Valid&In_Ready` edge writes the pixel to buffer[wr_idx], adds it to the channel sums (`PIX_W+LOG2_N` bits, no overflow possible) and increments wr_idx.
- MEAN: `Mean_x = sum_x >> LOG2_N`, truncating.
- EMIT: `Out_Valid`=1. Each channel difference is `|pix - mean|` (`PIX_W` bits). Distance is max of the three (Mode 0) or their sum (Mode 1, `PIX_W+2` bits).
  - If distance ≤ Threshold: output `Bg_*` with `Out_Replaced`=1.
  - Otherwise: output the buffered pixel with `Out_Replaced`=0.
  - Each `Out_Valid&Out_Ready` edge advances rd_idx and increments `Replace_Count` if replaced.
- DONE: outputs hold last values. `Mean_*` and `Replace_Count` stay stable until the next Start.

Reset and boundary rules:
- Reset (async, any state): state IDLE; `Qi`=1, other Q*=0. `In_Ready`, `Out_Valid`, `Out_Replaced` = 0. `Out_*`, `Mean_*`, `Replace_Count`, sums and indices = 0. Buffer contents don't-care.
- `Start` outside IDLE: ignored. `Ack` outside DONE: ignored.
- `Start` and `Ack` both high in IDLE: Start wins.
- `In_Valid` gaps in LOAD: wait, no timeout.
- `Out_Ready` low in EMIT: `Out_*` and `Out_Replaced` held stable.
- Start clears sums, `Replace_Count` and both indices.

## Timing
- `Start` sampled at edge k → LOAD from k+1; `In_Ready` high after k.
- Last input accepted at edge m → MEAN during (m, m+1]. EMIT from m+1, so `Out_Valid` is high after edge m+1. First pixel out 2 cycles after last pixel in.
- `Out_*` are combinational from registered buffer/mean/latched config; no extra latency in EMIT. Full throughput is one pixel per cycle each direction.
- Minimum tile time with no stalls: 1 + N + 1 + N cycles to DONE.

## Structure
- Package `bg_pkg`: state enum (IDLE, LOAD, MEAN, EMIT, DONE), mode constants `MODE_LINF`/`MODE_L1`.
- Sub-module `bg_dist`: combinational. Inputs are pixel, mean, Mode and Threshold; outputs are distance and replace flag. Parametrised by `PIX_W`.
- Buffer is a plain register array of `NUM_PIXELS` × 3×`PIX_W`.

## Test plan
- NUM_PIXELS=4, PIX_W=8. Pixels (61,133,198)×3 and (204,0,0); Mode 0, Threshold 60, Bg (106,168,79).
  - Expected: Mean (96,99,148).
  - Expected output: (106,168,79)×3 then (204,0,0); `Replace_Count`=3.
- Same tile, Mode 1, Threshold 60: all pixels pass through unchanged (blue L1=119), count 0.
- Same tile, Mode 1, Threshold 119: the three blue pixels are replaced (equality boundary); red is not (L1=355); count 3.
- Backpressure: `Out_Ready` toggled 1,0,0,1… and `In_Valid` with gaps.
  - Outputs stay stable while stalled; no pixel is lost or duplicated; order is preserved.
- Drive `Reset_n` low mid-EMIT, between edges: `Qi`=1 immediately, all outputs zero.
  - A new tile after release runs correctly.
- `Start` pulsed in LOAD and DONE: ignored. `Ack` in DONE returns to IDLE one edge later.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared types for the streaming background-removal processing element.
package bg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MEAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic MODE_LINF = 1'b0;
    localparam logic MODE_L1   = 1'b1;

endpackage

// File: rtl/bg_pe_stream_dist.sv
// Colour distance between a pixel and the tile mean, and the replace decision.
module bg_dist
    import bg_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    input  logic [PIX_W-1:0] mean_r,
    input  logic [PIX_W-1:0] mean_g,
    input  logic [PIX_W-1:0] mean_b,
    input  logic             mode,
    input  logic [PIX_W+1:0] threshold,
    output logic [PIX_W+1:0] distance,
    output logic             replace
);

    logic [PIX_W-1:0] d_r;
    logic [PIX_W-1:0] d_g;
    logic [PIX_W-1:0] d_b;
    logic [PIX_W-1:0] d_max_rg;
    logic [PIX_W-1:0] d_max;

    always_comb begin
        d_r      = (pix_r >= mean_r) ? pix_r - mean_r : mean_r - pix_r;
        d_g      = (pix_g >= mean_g) ? pix_g - mean_g : mean_g - pix_g;
        d_b      = (pix_b >= mean_b) ? pix_b - mean_b : mean_b - pix_b;
        d_max_rg = (d_r >= d_g) ? d_r : d_g;
        d_max    = (d_max_rg >= d_b) ? d_max_rg : d_b;
        if (mode == MODE_L1) begin
            distance = {2'b00, d_r} + {2'b00, d_g} + {2'b00, d_b};
        end else begin
            distance = {2'b00, d_max};
        end
        replace = (distance <= threshold);
    end

endmodule

// File: rtl/bg_pe_stream.sv
// Streaming background-removal PE: buffers a tile, computes its mean, then
// re-emits it with near-mean pixels replaced by the background colour.
module bg_pe_stream
    import bg_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int NUM_PIXELS = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Start,
    input  logic                          Ack,
    input  logic                          Mode,
    input  logic [PIX_W+1:0]              Threshold,
    input  logic [PIX_W-1:0]              Bg_R,
    input  logic [PIX_W-1:0]              Bg_G,
    input  logic [PIX_W-1:0]              Bg_B,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic [PIX_W-1:0]              In_R,
    input  logic [PIX_W-1:0]              In_G,
    input  logic [PIX_W-1:0]              In_B,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic [PIX_W-1:0]              Out_R,
    output logic [PIX_W-1:0]              Out_G,
    output logic [PIX_W-1:0]              Out_B,
    output logic                          Out_Replaced,
    output logic [PIX_W-1:0]              Mean_R,
    output logic [PIX_W-1:0]              Mean_G,
    output logic [PIX_W-1:0]              Mean_B,
    output logic [$clog2(NUM_PIXELS):0]   Replace_Count,
    output logic                          Qi,
    output logic                          Ql,
    output logic                          Qm,
    output logic                          Qe,
    output logic                          Qd
);

    localparam int LOG2_N = $clog2(NUM_PIXELS);
    localparam int SUM_W  = PIX_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(NUM_PIXELS - 1);

    state_t state, state_nx;

    logic                  mode_q;
    logic [PIX_W+1:0]      thr_q;
    logic [PIX_W-1:0]      bg_r_q, bg_g_q, bg_b_q;
    logic [SUM_W-1:0]      sum_r, sum_g, sum_b;
    logic [LOG2_N-1:0]     wr_idx, rd_idx;
    logic [3*PIX_W-1:0]    buf_mem [NUM_PIXELS];
    logic [3*PIX_W-1:0]    rd_pix;
    logic [PIX_W-1:0]      hold_r, hold_g, hold_b;
    logic                  hold_rep;
    logic [PIX_W+1:0]      dist_unused;
    logic                  rep_c;
    logic [PIX_W-1:0]      emit_r, emit_g, emit_b;
    logic                  start_fire, in_fire, out_fire;

    assign start_fire = (state == ST_IDLE) && Start;
    assign in_fire    = (state == ST_LOAD) && In_Valid;
    assign out_fire   = (state == ST_EMIT) && Out_Ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (Start) state_nx = ST_LOAD;
            ST_LOAD: if (in_fire && wr_idx == LAST_IDX) state_nx = ST_MEAN;
            ST_MEAN: state_nx = ST_EMIT;
            ST_EMIT: if (out_fire && rd_idx == LAST_IDX) state_nx = ST_DONE;
            ST_DONE: if (Ack) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Pixel storage carries no reset; its contents only matter after a LOAD.
    always_ff @(posedge Clk) begin
        if (in_fire) buf_mem[wr_idx] <= {In_R, In_G, In_B};
    end

    assign rd_pix = buf_mem[rd_idx];

    bg_dist #(.PIX_W(PIX_W)) u_dist (
        .pix_r     (rd_pix[3*PIX_W-1 -: PIX_W]),
        .pix_g     (rd_pix[2*PIX_W-1 -: PIX_W]),
        .pix_b     (rd_pix[PIX_W-1:0]),
        .mean_r    (Mean_R),
        .mean_g    (Mean_G),
        .mean_b    (Mean_B),
        .mode      (mode_q),
        .threshold (thr_q),
        .distance  (dist_unused),
        .replace   (rep_c)
    );

    always_comb begin
        emit_r = rep_c ? bg_r_q : rd_pix[3*PIX_W-1 -: PIX_W];
        emit_g = rep_c ? bg_g_q : rd_pix[2*PIX_W-1 -: PIX_W];
        emit_b = rep_c ? bg_b_q : rd_pix[PIX_W-1:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q        <= MODE_LINF;
            thr_q         <= '0;
            bg_r_q        <= '0;
            bg_g_q        <= '0;
            bg_b_q        <= '0;
            sum_r         <= '0;
            sum_g         <= '0;
            sum_b         <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            Mean_R        <= '0;
            Mean_G        <= '0;
            Mean_B        <= '0;
            Replace_Count <= '0;
            hold_r        <= '0;
            hold_g        <= '0;
            hold_b        <= '0;
            hold_rep      <= 1'b0;
        end else begin
            if (start_fire) begin
                mode_q        <= Mode;
                thr_q         <= Threshold;
                bg_r_q        <= Bg_R;
                bg_g_q        <= Bg_G;
                bg_b_q        <= Bg_B;
                sum_r         <= '0;
                sum_g         <= '0;
                sum_b         <= '0;
                wr_idx        <= '0;
                rd_idx        <= '0;
                Replace_Count <= '0;
            end
            if (in_fire) begin
                sum_r  <= sum_r + SUM_W'(In_R);
                sum_g  <= sum_g + SUM_W'(In_G);
                sum_b  <= sum_b + SUM_W'(In_B);
                wr_idx <= wr_idx + 1'b1;
            end
            if (state == ST_MEAN) begin
                Mean_R <= PIX_W'(sum_r >> LOG2_N);
                Mean_G <= PIX_W'(sum_g >> LOG2_N);
                Mean_B <= PIX_W'(sum_b >> LOG2_N);
            end
            // The last transferred pixel is kept so outputs hold after EMIT.
            if (out_fire) begin
                rd_idx        <= rd_idx + 1'b1;
                Replace_Count <= Replace_Count + (LOG2_N + 1)'(rep_c);
                hold_r        <= emit_r;
                hold_g        <= emit_g;
                hold_b        <= emit_b;
                hold_rep      <= rep_c;
            end
        end
    end

    always_comb begin
        Out_R        = hold_r;
        Out_G        = hold_g;
        Out_B        = hold_b;
        Out_Replaced = hold_rep;
        if (state == ST_EMIT) begin
            Out_R        = emit_r;
            Out_G        = emit_g;
            Out_B        = emit_b;
            Out_Replaced = rep_c;
        end
    end

    assign In_Ready  = (state == ST_LOAD);
    assign Out_Valid = (state == ST_EMIT);
    assign Qi        = (state == ST_IDLE);
    assign Ql        = (state == ST_LOAD);
    assign Qm        = (state == ST_MEAN);
    assign Qe        = (state == ST_EMIT);
    assign Qd        = (state == ST_DONE);

endmodule

// File: tb/tb_bg_pe_stream.sv
// Directed table-driven bench for bg_pe_stream with a 4-pixel tile.
module tb_bg_pe_stream;

    localparam int PW = 8;
    localparam int NP = 4;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start, Ack, Mode;
    logic [PW+1:0] Threshold;
    logic [PW-1:0] Bg_R, Bg_G, Bg_B;
    logic          In_Valid, In_Ready;
    logic [PW-1:0] In_R, In_G, In_B;
    logic          Out_Valid, Out_Ready;
    logic [PW-1:0] Out_R, Out_G, Out_B;
    logic          Out_Replaced;
    logic [PW-1:0] Mean_R, Mean_G, Mean_B;
    logic [2:0]    Replace_Count;
    logic          Qi, Ql, Qm, Qe, Qd;

    bg_pe_stream #(.PIX_W(PW), .NUM_PIXELS(NP)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Mode(Mode),
        .Threshold(Threshold), .Bg_R(Bg_R), .Bg_G(Bg_G), .Bg_B(Bg_B),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_R(In_R), .In_G(In_G), .In_B(In_B),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_R(Out_R), .Out_G(Out_G),
        .Out_B(Out_B), .Out_Replaced(Out_Replaced), .Mean_R(Mean_R), .Mean_G(Mean_G),
        .Mean_B(Mean_B), .Replace_Count(Replace_Count),
        .Qi(Qi), .Ql(Ql), .Qm(Qm), .Qe(Qe), .Qd(Qd)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        mode;
        logic [9:0]  thr;
        logic [23:0] bg;
        logic [95:0] pix;   // pixel i at [i*24 +: 24], {R,G,B}
        logic [23:0] mean;
        logic [3:0]  rep;
        logic [2:0]  cnt;
        logic        bp;
    } vec_t;

    localparam logic [23:0] BLUE = {8'd61, 8'd133, 8'd198};
    localparam logic [23:0] RED  = {8'd204, 8'd0, 8'd0};
    localparam logic [23:0] BG   = {8'd106, 8'd168, 8'd79};
    localparam logic [23:0] MEAN = {8'd96, 8'd99, 8'd148};
    localparam logic [23:0] FLAT = {8'd10, 8'd20, 8'd30};

    vec_t vecs[5];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int stop_at);
        logic [23:0] expo;
        int          idx;
        int          cyc;
        expo = '0;
        @(negedge Clk);
        Mode = v.mode;
        Threshold = v.thr;
        {Bg_R, Bg_G, Bg_B} = v.bg;
        Start = 1'b1;
        Ack = v.bp;
        @(negedge Clk);
        Start = 1'b0;
        Ack = 1'b0;
        chk("start_to_load", {26'd0, Qi, Ql, Qm, Qe, Qd, In_Ready}, 32'b010001);
        Mode = ~v.mode;
        Threshold = '0;
        {Bg_R, Bg_G, Bg_B} = ~v.bg;
        for (int i = 0; i < NP; i++) begin
            if (v.bp && (i % 2 == 1)) begin
                In_Valid = 1'b0;
                Start = 1'b1;
                Ack = 1'b1;
                @(negedge Clk);
                Start = 1'b0;
                Ack = 1'b0;
            end
            In_Valid = 1'b1;
            {In_R, In_G, In_B} = v.pix[i*24 +: 24];
            chk("in_ready", {31'd0, In_Ready}, 32'd1);
            @(negedge Clk);
        end
        In_Valid = 1'b0;
        chk("mean_state", {27'd0, Ql, Qm, Qe, In_Ready, Out_Valid}, 32'b01000);
        @(negedge Clk);
        chk("emit_state", {29'd0, Qm, Qe, Out_Valid}, 32'b011);
        chk("mean", {8'd0, Mean_R, Mean_G, Mean_B}, {8'd0, v.mean});
        idx = 0;
        cyc = 0;
        while (idx < NP && cyc < 100) begin
            if (idx == stop_at) return;
            Out_Ready = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            expo = v.rep[idx] ? v.bg : v.pix[idx*24 +: 24];
            if (Out_Ready) begin
                chk("out_valid", {31'd0, Out_Valid}, 32'd1);
                chk("out_pix", {8'd0, Out_R, Out_G, Out_B}, {8'd0, expo});
                chk("out_rep", {31'd0, Out_Replaced}, {31'd0, v.rep[idx]});
                @(negedge Clk);
                idx++;
            end else begin
                @(negedge Clk);
                chk("stall_pix", {7'd0, Out_Replaced, Out_R, Out_G, Out_B},
                    {7'd0, v.rep[idx], expo});
            end
            cyc++;
        end
        if (idx < NP) chk("emit_timeout", idx, NP);
        Out_Ready = 1'b0;
        chk("done_state", {29'd0, Qe, Qd, Out_Valid}, 32'b010);
        chk("count", {29'd0, Replace_Count}, {29'd0, v.cnt});
        chk("done_hold", {8'd0, Out_R, Out_G, Out_B}, {8'd0, expo});
        chk("mean_hold", {8'd0, Mean_R, Mean_G, Mean_B}, {8'd0, v.mean});
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_in_done", {30'd0, Qi, Qd}, 32'b01);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_to_idle", {30'd0, Qi, Qd}, 32'b10);
        chk("count_idle", {29'd0, Replace_Count}, {29'd0, v.cnt});
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {25'd0, Qi, Ql, Qm, Qe, Qd, In_Ready, Out_Valid}, 32'b1000000);
        chk({name, "_out"}, {7'd0, Out_Replaced, Out_R, Out_G, Out_B}, 32'd0);
        chk({name, "_mean"}, {8'd0, Mean_R, Mean_G, Mean_B}, 32'd0);
        chk({name, "_cnt"}, {29'd0, Replace_Count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        Start = 1'b0; Ack = 1'b0; Mode = 1'b0; Threshold = '0;
        Bg_R = '0; Bg_G = '0; Bg_B = '0;
        In_Valid = 1'b0; In_R = '0; In_G = '0; In_B = '0;
        Out_Ready = 1'b0;

        vecs[0] = '{mode: 1'b0, thr: 10'd60,  bg: BG, pix: {RED, BLUE, BLUE, BLUE},
                    mean: MEAN, rep: 4'b0111, cnt: 3'd3, bp: 1'b0};
        vecs[1] = '{mode: 1'b1, thr: 10'd60,  bg: BG, pix: {RED, BLUE, BLUE, BLUE},
                    mean: MEAN, rep: 4'b0000, cnt: 3'd0, bp: 1'b1};
        vecs[2] = '{mode: 1'b1, thr: 10'd119, bg: BG, pix: {RED, BLUE, BLUE, BLUE},
                    mean: MEAN, rep: 4'b0111, cnt: 3'd3, bp: 1'b0};
        vecs[3] = '{mode: 1'b0, thr: 10'd49,  bg: BG, pix: {RED, BLUE, BLUE, BLUE},
                    mean: MEAN, rep: 4'b0000, cnt: 3'd0, bp: 1'b0};
        vecs[4] = '{mode: 1'b0, thr: 10'd0,   bg: {8'd1, 8'd2, 8'd3}, pix: {4{FLAT}},
                    mean: FLAT, rep: 4'b1111, cnt: 3'd4, bp: 1'b1};

        repeat (2) @(negedge Clk);
        chk_reset_state("reset");
        Reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], -1);

        // Abort a tile two pixels into EMIT with reset asserted between edges.
        run_vec(vecs[0], 2);
        #2 Reset_n = 1'b0;
        #1 chk_reset_state("async_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        Out_Ready = 1'b0;
        run_vec(vecs[1], -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
